// File: rtl/pipeline_control_unit.sv
// ---------------------------------------------------------------------------
// pipeline_control_unit
//
// ID-stage control for the pipelined MIPS core. Decodes the ID instruction
// into register fields, tracks in-flight destination registers in a
// DEPTH-entry scoreboard (entry 0 = EX, entry DEPTH-1 = last tracked stage),
// and from that produces stall / issue / flush and operand forwarding selects.
// A three-state machine (RUN, DRAIN, HALTED) drains the pipe after HALT.
//
// Optional feature macro: PIPELINE_CONTROL_UNIT_FWD_EN
//   defined   : operands forward from the youngest matching entry; only a
//               load sitting in entry 0 that feeds a read source stalls.
//   undefined : fwd_a/fwd_b are 0 and any scoreboard match stalls.
//
// Parameters:
//   DEPTH         stages tracked after ID (1..7)
//   FW            forwarding select width, derived from DEPTH
//
// Ports:
//   CLK           core clock, rising edge
//   nRST          synchronous active-low reset
//   instr         ID-stage instruction word
//   id_valid      instr is a real instruction
//   ex_ready      EX accepts a new instruction this cycle
//   branch_taken  EX redirect; squash ID
//   rs, rt        decoded source fields
//   dest          decoded destination (0 = no write)
//   issue         ID instruction enters EX at this edge
//   stall         hold PC and IF/ID
//   flush         squash IF/ID
//   fwd_a, fwd_b  0 = register file, k = scoreboard entry k-1
//   halt          pipeline drained after HALT (sticky until reset)
// ---------------------------------------------------------------------------

// Per-entry source comparator: one instance per scoreboard entry.
module pcu_sb_match (
    input  logic       ent_valid,
    input  logic [4:0] ent_reg,
    input  logic       rd_a,
    input  logic [4:0] src_a,
    input  logic       rd_b,
    input  logic [4:0] src_b,
    output logic       hit_a,
    output logic       hit_b
);
    // $0 is never a producer, so it never matches even if a stale entry held 0.
    assign hit_a = ent_valid && rd_a && (src_a != 5'd0) && (ent_reg == src_a);
    assign hit_b = ent_valid && rd_b && (src_b != 5'd0) && (ent_reg == src_b);
endmodule

module pipeline_control_unit #(
    parameter  int DEPTH = 3,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [31:0]   instr,
    input  logic          id_valid,
    input  logic          ex_ready,
    input  logic          branch_taken,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    dest,
    output logic          issue,
    output logic          stall,
    output logic          flush,
    output logic [FW-1:0] fwd_a,
    output logic [FW-1:0] fwd_b,
    output logic          halt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rgs;
        logic       is_load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    state_t                state_q, state_d;

    // ---------------------------------------------------------------- decode
    logic [5:0] op, funct;
    logic [4:0] f_rs, f_rt, f_rd;
    logic       rd_a, rd_b;
    logic [4:0] wr_reg;
    logic       wr_load;
    logic       is_halt;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign f_rs  = instr[25:21];
    assign f_rt  = instr[20:16];
    assign f_rd  = instr[15:11];

    always_comb begin
        rd_a    = 1'b0;
        rd_b    = 1'b0;
        wr_reg  = 5'd0;
        wr_load = 1'b0;
        is_halt = 1'b0;
        case (op)
            6'h00: begin
                rd_a = 1'b1;
                if (funct != 6'h08) begin       // JR reads rs only
                    rd_b   = 1'b1;
                    wr_reg = f_rd;
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                rd_a   = 1'b1;
                wr_reg = f_rt;
            end
            6'h0F: wr_reg = f_rt;               // LUI
            6'h23: begin                        // LW
                rd_a    = 1'b1;
                wr_reg  = f_rt;
                wr_load = 1'b1;
            end
            6'h2B, 6'h04, 6'h05: begin          // SW, BEQ, BNE
                rd_a = 1'b1;
                rd_b = 1'b1;
            end
            6'h03:   wr_reg  = 5'd31;           // JAL
            6'h3F:   is_halt = 1'b1;
            default: ;                          // J and unknown: no effect
        endcase
    end

    // A bubble reads nothing, so it can never raise a hazard.
    logic use_a, use_b;
    assign use_a = id_valid && rd_a;
    assign use_b = id_valid && rd_b;

    // ------------------------------------------------------ scoreboard match
    logic [DEPTH-1:0] hit_a, hit_b;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        pcu_sb_match u_match (
            .ent_valid (sb_q[g].valid),
            .ent_reg   (sb_q[g].rgs),
            .rd_a      (use_a),
            .src_a     (f_rs),
            .rd_b      (use_b),
            .src_b     (f_rt),
            .hit_a     (hit_a[g]),
            .hit_b     (hit_b[g])
        );
    end

    logic          hazard;
    logic [FW-1:0] fwd_a_c, fwd_b_c;

`ifdef PIPELINE_CONTROL_UNIT_FWD_EN
    // Walk oldest to youngest so the lowest-numbered (youngest) hit wins.
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit_a[k]) fwd_a_c = FW'(k + 1);
            if (hit_b[k]) fwd_b_c = FW'(k + 1);
        end
    end
    // Load data is not available until it leaves EX: one bubble of load-use.
    assign hazard = sb_q[0].is_load && (hit_a[0] || hit_b[0]);
`else
    assign fwd_a_c = '0;
    assign fwd_b_c = '0;
    assign hazard  = (|hit_a) || (|hit_b);
`endif

    // --------------------------------------------------------------- control
    logic issue_c, stall_c, flush_c;

    always_comb begin
        issue_c = 1'b0;
        stall_c = 1'b0;
        flush_c = 1'b0;
        if (!nRST) begin
            // everything stays 0 while reset is asserted
        end else if (state_q == S_RUN && branch_taken) begin
            flush_c = 1'b1;
        end else if (state_q != S_RUN) begin
            stall_c = 1'b1;
        end else if (!ex_ready || hazard) begin
            stall_c = 1'b1;
        end else begin
            issue_c = id_valid;
        end
    end

    // ------------------------------------------------------- scoreboard next
    always_comb begin
        sb_d = sb_q;
        if (ex_ready) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb_d[k] = sb_q[k - 1];
            end
            // HALT and $0 writers enter as no-write (invalid) entries.
            sb_d[0].valid   = issue_c && (wr_reg != 5'd0);
            sb_d[0].rgs     = issue_c ? wr_reg : 5'd0;
            sb_d[0].is_load = issue_c && wr_load;
        end
    end

    logic any_valid;
    always_comb begin
        any_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            any_valid = any_valid | sb_q[k].valid;
        end
    end

    // ------------------------------------------------------------- halt FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (issue_c && is_halt) state_d = S_DRAIN;
            S_DRAIN:  if (!any_valid)         state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sb_q    <= '0;
            state_q <= S_RUN;
        end else begin
            sb_q    <= sb_d;
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign rs    = nRST ? f_rs    : 5'd0;
    assign rt    = nRST ? f_rt    : 5'd0;
    assign dest  = nRST ? wr_reg  : 5'd0;
    assign fwd_a = nRST ? fwd_a_c : '0;
    assign fwd_b = nRST ? fwd_b_c : '0;
    assign issue = issue_c;
    assign stall = stall_c;
    assign flush = flush_c;
    assign halt  = nRST && (state_q == S_HALTED);

    // Shamt field and the retiring entry's load flag have no consumer.
    logic unused_bits;
    assign unused_bits = ^{instr[10:6], sb_q[DEPTH-1].is_load};

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;
    localparam int DEPTH = 3;
    localparam int FW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          nRST;
    logic [31:0]   instr;
    logic          id_valid, ex_ready, branch_taken;
    logic [4:0]    rs, rt, dest;
    logic          issue, stall, flush, halt;
    logic [FW-1:0] fwd_a, fwd_b;

    always #5 CLK = ~CLK;

    pipeline_control_unit #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST), .instr(instr), .id_valid(id_valid),
        .ex_ready(ex_ready), .branch_taken(branch_taken),
        .rs(rs), .rt(rt), .dest(dest), .issue(issue), .stall(stall),
        .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .halt(halt)
    );

    typedef struct packed {
        logic [4:0]    rs, rt, dest;
        logic          issue, stall, flush;
        logic [FW-1:0] fa, fb;
        logic          halt;
    } out_t;

    out_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // ------------------------------------------------------ reference model
    // In-flight writers with their age in accepted EX advances (0 = in EX).
    typedef struct {
        int rg;
        bit ld;
        int age;
    } fl_t;
    fl_t infl[$];
    int  mstate = 0;  // 0 running, 1 draining, 2 halted

    function automatic void decode(input logic [31:0] ins, output bit ra,
                                   output bit rb, output int wd, output bit ld);
        int op;
        op = int'(ins[31:26]);
        ra = 0; rb = 0; wd = 0; ld = 0;
        if (op == 0) begin
            ra = 1;
            if (ins[5:0] != 6'h08) begin rb = 1; wd = int'(ins[15:11]); end
        end else if (op >= 8 && op <= 14) begin ra = 1; wd = int'(ins[20:16]); end
        else if (op == 15) wd = int'(ins[20:16]);
        else if (op == 35) begin ra = 1; wd = int'(ins[20:16]); ld = 1; end
        else if (op == 43 || op == 4 || op == 5) begin ra = 1; rb = 1; end
        else if (op == 3) wd = 31;
    endfunction

    function automatic out_t model_out(input logic [31:0] ins, input bit v,
                                       input bit er, input bit br, input bit rst_n);
        out_t o;
        bit ra, rb, ld, haz;
        int wd, s, t, fa, fb;
        o = '0;
        if (!rst_n) return o;
        decode(ins, ra, rb, wd, ld);
        s = int'(ins[25:21]);
        t = int'(ins[20:16]);
        o.rs = ins[25:21];
        o.rt = ins[20:16];
        o.dest = wd[4:0];
        haz = 0; fa = 0; fb = 0;
        foreach (infl[i]) begin
            bit ma, mb;
            ma = v && ra && s != 0 && infl[i].rg == s;
            mb = v && rb && t != 0 && infl[i].rg == t;
`ifdef PIPELINE_CONTROL_UNIT_FWD_EN
            if ((ma || mb) && infl[i].age == 0 && infl[i].ld) haz = 1;
            if (ma && (fa == 0 || infl[i].age + 1 < fa)) fa = infl[i].age + 1;
            if (mb && (fb == 0 || infl[i].age + 1 < fb)) fb = infl[i].age + 1;
`else
            if (ma || mb) haz = 1;
`endif
        end
        o.fa = fa[FW-1:0];
        o.fb = fb[FW-1:0];
        if (mstate == 0 && br) o.flush = 1;
        else if (mstate != 0) o.stall = 1;
        else if (!er || haz) o.stall = 1;
        else o.issue = v;
        o.halt = (mstate == 2);
        return o;
    endfunction

    function automatic void model_edge(input logic [31:0] ins, input bit er,
                                       input bit rst_n, input out_t o);
        bit ra, rb, ld;
        int wd, nxt;
        fl_t nq[$];
        if (!rst_n) begin
            infl.delete();
            mstate = 0;
            return;
        end
        decode(ins, ra, rb, wd, ld);
        nxt = mstate;
        if (mstate == 0 && o.issue && ins[31:26] == 6'h3F) nxt = 1;
        if (mstate == 1 && infl.size() == 0) nxt = 2;
        if (er) begin
            foreach (infl[i]) begin
                fl_t e;
                e = infl[i];
                e.age++;
                if (e.age < DEPTH) nq.push_back(e);
            end
            if (o.issue && wd != 0) begin
                fl_t n;
                n.rg = wd; n.ld = ld; n.age = 0;
                nq.push_back(n);
            end
            infl = nq;
        end
        mstate = nxt;
    endfunction

    // ------------------------------------------------------------ monitor
    out_t m_exp, m_got;
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                m_exp = exp_q.pop_front();
                m_got = '{rs: rs, rt: rt, dest: dest, issue: issue, stall: stall,
                          flush: flush, fa: fwd_a, fb: fwd_b, halt: halt};
                n_tests++;
                if (m_got !== m_exp) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got rs=%0d rt=%0d dest=%0d iss=%b stl=%b fl=%b fa=%0d fb=%0d halt=%b | exp rs=%0d rt=%0d dest=%0d iss=%b stl=%b fl=%b fa=%0d fb=%0d halt=%b",
                             $time, m_got.rs, m_got.rt, m_got.dest, m_got.issue, m_got.stall,
                             m_got.flush, m_got.fa, m_got.fb, m_got.halt,
                             m_exp.rs, m_exp.rt, m_exp.dest, m_exp.issue, m_exp.stall,
                             m_exp.flush, m_exp.fa, m_exp.fb, m_exp.halt);
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    logic s_issue, s_stall;

    task automatic check(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic [31:0] ins, input bit v, input bit er,
                        input bit br, input bit rst_n);
        out_t e;
        instr = ins; id_valid = v; ex_ready = er; branch_taken = br; nRST = rst_n;
        e = model_out(ins, v, er, br, rst_n);
        exp_q.push_back(e);
        #3;
        s_issue = issue;
        s_stall = stall;
        @(posedge CLK);
        model_edge(ins, er, rst_n, e);
        #1;
    endtask

    task automatic hold_until_issue(input logic [31:0] ins, output int stalls);
        bit done;
        stalls = 0;
        done   = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(ins, 1, 1, 0, 1);
            if (s_issue) done = 1;
            else if (s_stall) stalls++;
        end
        if (!done) stalls = -1;
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) step(32'd0, 0, 1, 0, 1);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [4:0]  s, t, d;
        logic [25:0] tgt;
        s = 5'($urandom_range(0, 5));
        t = 5'($urandom_range(0, 5));
        d = 5'($urandom_range(0, 5));
        tgt = 26'($urandom);
        case ($urandom_range(0, 11))
            0:  return rtype(s, t, d, 6'h20);
            1:  return rtype(s, t, d, 6'h22);
            2:  return rtype(s, t, d, 6'h08);
            3:  return itype(6'($urandom_range(8, 14)), s, t, 16'($urandom));
            4:  return itype(6'h0F, s, t, 16'($urandom));
            5:  return itype(6'h23, s, t, 16'($urandom));
            6:  return itype(6'h2B, s, t, 16'($urandom));
            7:  return itype(6'($urandom_range(4, 5)), s, t, 16'($urandom));
            8:  return {6'h03, tgt};
            9:  return {6'h02, tgt};
            10: return itype(6'h1C, s, t, 16'($urandom));
            default: return ($urandom_range(0, 9) == 0) ? {6'h3F, 26'd0}
                                                        : rtype(s, t, d, 6'h20);
        endcase
    endfunction

    localparam logic [31:0] HALT_I = {6'h3F, 26'd0};

    initial begin
        int st, exp_st, edges;
        bit done;
        instr = 0; id_valid = 0; ex_ready = 0; branch_taken = 0; nRST = 0;
        @(posedge CLK);
        #1;

        // reset held two cycles with a live ADD in ID
        step(rtype(1, 2, 3, 6'h20), 1, 1, 0, 0);
        step(rtype(1, 2, 3, 6'h20), 1, 1, 0, 0);

        // dependent back-to-back ALU pair
        step(rtype(1, 2, 3, 6'h20), 1, 1, 0, 1);
        hold_until_issue(rtype(3, 1, 4, 6'h22), st);
`ifdef PIPELINE_CONTROL_UNIT_FWD_EN
        exp_st = 0;
`else
        exp_st = DEPTH;
`endif
        check("alu_pair_stalls", st, exp_st);
        bubbles(DEPTH);

        // $0 producer never creates a hazard
        step(itype(6'h08, 1, 0, 16'd5), 1, 1, 0, 1);
        hold_until_issue(rtype(0, 0, 5, 6'h20), st);
        check("zero_reg_stalls", st, 0);
        bubbles(DEPTH);

        // one independent instruction between producer and consumer
        step(rtype(1, 2, 3, 6'h20), 1, 1, 0, 1);
        step(rtype(1, 2, 7, 6'h20), 1, 1, 0, 1);
        hold_until_issue(rtype(3, 1, 4, 6'h22), st);
`ifdef PIPELINE_CONTROL_UNIT_FWD_EN
        exp_st = 0;
`else
        exp_st = DEPTH - 1;
`endif
        check("gap1_stalls", st, exp_st);
        bubbles(DEPTH);

        // load-use
        step(itype(6'h23, 1, 5, 16'd0), 1, 1, 0, 1);
        hold_until_issue(rtype(5, 5, 6, 6'h20), st);
`ifdef PIPELINE_CONTROL_UNIT_FWD_EN
        exp_st = 1;
`else
        exp_st = DEPTH;
`endif
        check("load_use_stalls", st, exp_st);
        bubbles(DEPTH);

        // branch during a hazard stall
        step(rtype(1, 2, 3, 6'h20), 1, 1, 0, 1);
        step(itype(6'h23, 3, 4, 16'd0), 1, 1, 0, 1);
        step(rtype(3, 4, 6, 6'h20), 1, 1, 1, 1);
        hold_until_issue(rtype(3, 1, 4, 6'h22), st);
        check("post_branch_done", int'(st >= 0), 1);
        bubbles(DEPTH);

        // randomized traffic, occasional resets
        step(32'd0, 0, 1, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            step(rand_ins(), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 149) != 0);
        end

        // halt drain: two in flight, one ex_ready=0 cycle
        step(32'd0, 0, 1, 0, 0);
        step(rtype(2, 3, 1, 6'h20), 1, 1, 0, 1);
        step(rtype(4, 5, 2, 6'h20), 1, 1, 0, 1);
        step(HALT_I, 1, 1, 0, 1);
        check("halt_issued", int'(s_issue), 1);
        edges = 0;
        done  = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(rtype(1, 2, 3, 6'h20), 1, i != 0, 0, 1);
            edges++;
            if (halt) done = 1;
        end
        check("halt_edges", done ? edges : -1, DEPTH + 1);
        for (int i = 0; i < 4; i++) step(rtype(1, 2, 3, 6'h20), 1, 1, 1, 1);
        check("halt_sticky", int'(halt), 1);
        step(32'd0, 0, 1, 0, 0);
        check("halt_cleared", int'(halt), 0);

        // reset mid-drain aborts the drain
        step(rtype(2, 3, 1, 6'h20), 1, 1, 0, 1);
        step(HALT_I, 1, 1, 0, 1);
        step(32'd0, 0, 1, 0, 1);
        step(32'd0, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) step(rtype(1, 2, 3, 6'h20), 1, 1, 0, 1);
        check("abort_drain_halt", int'(halt), 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
